axi_lite_req_master: RTL and testbench

Upstream master stage that converts a simple single-beat request/response interface into AXI4-Lite master transactions. It drives axi_lite_scratchpad or any AXI4-Lite slave with the same channel set. It sits between an internal controller (sequencer, CPU shim, test driver) and the scratchpad slave port. One transaction is in flight at a time, and all AXI signals are registered.

---
 rtl/axi_lite_pkg.sv | 20 ++
 rtl/axi_lite_req_master.sv | 176 +++++++++++++++++
 tb/tb_axi_lite_req_master.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite request master: FSM state encoding and AXI response codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_req_master.sv
// Converts single-beat req/rsp transfers into AXI4-Lite master transactions, one in flight.
// Latency: AXI valid 1 cycle after request accept; min turnaround accept->rsp 3 cycles, ready again at 4.
// Backpressure: o_req_ready only in IDLE; every AXI valid and o_rsp_valid held stable until its handshake.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_req_* / o_req_ready      request channel (we, addr, wdata, wstrb)
//   o_rsp_* / i_rsp_ready      response channel (we echo, rdata, resp)
//   o_axi_aw*/w*/b*/ar*/r*     AXI4-Lite master channels, all outputs registered
module axi_lite_req_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_BW_p = 12,
    parameter int DATA_BW_p = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [ADDR_BW_p-1:0]     i_req_addr,
    input  logic [DATA_BW_p-1:0]     i_req_wdata,
    input  logic [DATA_BW_p/8-1:0]   i_req_wstrb,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic                     o_rsp_we,
    output logic [DATA_BW_p-1:0]     o_rsp_rdata,
    output logic [1:0]               o_rsp_resp,
    output logic [ADDR_BW_p-1:0]     o_axi_awaddr,
    output logic                     o_axi_awvalid,
    input  logic                     i_axi_awready,
    output logic [DATA_BW_p-1:0]     o_axi_wdata,
    output logic [DATA_BW_p/8-1:0]   o_axi_wstrb,
    output logic                     o_axi_wvalid,
    input  logic                     i_axi_wready,
    input  logic [1:0]               i_axi_bresp,
    input  logic                     i_axi_bvalid,
    output logic                     o_axi_bready,
    output logic [ADDR_BW_p-1:0]     o_axi_araddr,
    output logic                     o_axi_arvalid,
    input  logic                     i_axi_arready,
    input  logic [DATA_BW_p-1:0]     i_axi_rdata,
    input  logic [1:0]               i_axi_rresp,
    input  logic                     i_axi_rvalid,
    output logic                     o_axi_rready
);

    localparam int STRB_BW = DATA_BW_p / 8;

    state_e                 r_state;
    state_e                 w_state_nxt;

    logic                   r_req_ready;
    logic                   r_we;
    logic [ADDR_BW_p-1:0]   r_addr;
    logic [DATA_BW_p-1:0]   r_wdata;
    logic [STRB_BW-1:0]     r_wstrb;
    logic                   r_aw_done;
    logic                   r_w_done;
    logic                   r_awvalid;
    logic                   r_wvalid;
    logic                   r_bready;
    logic                   r_arvalid;
    logic                   r_rready;
    logic                   r_rsp_valid;
    logic [DATA_BW_p-1:0]   r_rsp_rdata;
    logic [1:0]             r_rsp_resp;

    logic                   w_req_hs;
    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_b_hs;
    logic                   w_ar_hs;
    logic                   w_r_hs;
    logic                   w_rsp_hs;
    logic                   w_aw_done_nxt;
    logic                   w_w_done_nxt;

    assign w_req_hs = i_req_valid & r_req_ready;
    assign w_aw_hs  = r_awvalid   & i_axi_awready;
    assign w_w_hs   = r_wvalid    & i_axi_wready;
    assign w_b_hs   = r_bready    & i_axi_bvalid;
    assign w_ar_hs  = r_arvalid   & i_axi_arready;
    assign w_r_hs   = r_rready    & i_axi_rvalid;
    assign w_rsp_hs = r_rsp_valid & i_rsp_ready;

    // Done flags include this cycle's handshake so a same-cycle AW+W completion
    // (or the second of two staggered ones) moves straight on to WR_RESP.
    assign w_aw_done_nxt = r_aw_done | w_aw_hs;
    assign w_w_done_nxt  = r_w_done  | w_w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_hs)                      w_state_nxt = i_req_we ? WR : RD_ADDR;
            WR:      if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = WR_RESP;
            WR_RESP: if (w_b_hs)                        w_state_nxt = RSP;
            RD_ADDR: if (w_ar_hs)                       w_state_nxt = RD_DATA;
            RD_DATA: if (w_r_hs)                        w_state_nxt = RSP;
            RSP:     if (w_rsp_hs)                      w_state_nxt = IDLE;
            default:                                    w_state_nxt = IDLE;
        endcase
    end

    // All outputs are registered decodes of the next state, so each one is
    // valid in the first cycle of the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_aw_done   <= (w_state_nxt == WR) & w_aw_done_nxt;
            r_w_done    <= (w_state_nxt == WR) & w_w_done_nxt;
            r_awvalid   <= (w_state_nxt == WR) & ~w_aw_done_nxt;
            r_wvalid    <= (w_state_nxt == WR) & ~w_w_done_nxt;
            r_bready    <= (w_state_nxt == WR_RESP);
            r_arvalid   <= (w_state_nxt == RD_ADDR);
            r_rready    <= (w_state_nxt == RD_DATA);
            r_rsp_valid <= (w_state_nxt == RSP);

            if (w_req_hs) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_wstrb <= i_req_wstrb;
            end
            if (w_b_hs) begin
                r_rsp_resp  <= i_axi_bresp;
                r_rsp_rdata <= '0;
            end
            if (w_r_hs) begin
                r_rsp_resp  <= i_axi_rresp;
                r_rsp_rdata <= i_axi_rdata;
            end
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_we      = r_we;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_resp    = r_rsp_resp;
    // One captured address serves both AW and AR; only one of them is ever valid.
    assign o_axi_awaddr  = r_addr;
    assign o_axi_araddr  = r_addr;
    assign o_axi_awvalid = r_awvalid;
    assign o_axi_wdata   = r_wdata;
    assign o_axi_wstrb   = r_wstrb;
    assign o_axi_wvalid  = r_wvalid;
    assign o_axi_bready  = r_bready;
    assign o_axi_arvalid = r_arvalid;
    assign o_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_req_master.sv
module tb_axi_lite_req_master;
    import axi_lite_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_req_valid = 0, i_req_we = 0, i_rsp_ready = 1;
    logic [11:0] i_req_addr = 0;
    logic [31:0] i_req_wdata = 0;
    logic [3:0]  i_req_wstrb = 0;
    logic        o_req_ready, o_rsp_valid, o_rsp_we;
    logic [31:0] o_rsp_rdata;
    logic [1:0]  o_rsp_resp;
    logic [11:0] o_axi_awaddr, o_axi_araddr;
    logic        o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
    logic [31:0] o_axi_wdata;
    logic [3:0]  o_axi_wstrb;
    logic [1:0]  i_axi_bresp, i_axi_rresp;
    logic        i_axi_bvalid, o_axi_bready, o_axi_arvalid, i_axi_arready;
    logic [31:0] i_axi_rdata;
    logic        i_axi_rvalid, o_axi_rready;

    axi_lite_req_master #(.ADDR_BW_p(12), .DATA_BW_p(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_we(o_rsp_we),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
        .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
        .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb), .o_axi_wvalid(o_axi_wvalid),
        .i_axi_wready(i_axi_wready), .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid),
        .o_axi_bready(o_axi_bready), .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid),
        .i_axi_arready(i_axi_arready), .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
        .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- slave stub: scratchpad-like RAM with programmable waits ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  sl_bresp = RESP_OKAY, sl_rresp = RESP_OKAY;
    logic        sl_rforce = 0;
    logic [31:0] sl_rval = 0;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    int          b_count = 0;
    logic        got_aw, got_w, got_ar;
    logic [11:0] sl_awaddr, sl_araddr, sl_wa, sl_ra;
    logic [31:0] sl_wdata, sl_wd;
    logic [3:0]  sl_wstrb, sl_ws;
    logic [31:0] mem [0:1023];

    initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    assign i_axi_awready = o_axi_awvalid && (aw_wait >= aw_dly);
    assign i_axi_wready  = o_axi_wvalid  && (w_wait  >= w_dly);
    assign i_axi_arready = o_axi_arvalid && (ar_wait >= ar_dly);
    assign sl_wa = got_aw ? sl_awaddr : o_axi_awaddr;
    assign sl_wd = got_w  ? sl_wdata  : o_axi_wdata;
    assign sl_ws = got_w  ? sl_wstrb  : o_axi_wstrb;
    assign sl_ra = got_ar ? sl_araddr : o_axi_araddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            got_aw <= 0; got_w <= 0; got_ar <= 0;
            i_axi_bvalid <= 0; i_axi_rvalid <= 0;
            i_axi_bresp <= 0; i_axi_rresp <= 0; i_axi_rdata <= 0;
            sl_awaddr <= 0; sl_araddr <= 0; sl_wdata <= 0; sl_wstrb <= 0;
        end else begin
            aw_wait <= (o_axi_awvalid && !i_axi_awready) ? aw_wait + 1 : 0;
            w_wait  <= (o_axi_wvalid  && !i_axi_wready)  ? w_wait + 1  : 0;
            ar_wait <= (o_axi_arvalid && !i_axi_arready) ? ar_wait + 1 : 0;
            if (o_axi_awvalid && i_axi_awready) begin got_aw <= 1; sl_awaddr <= o_axi_awaddr; end
            if (o_axi_wvalid && i_axi_wready) begin
                got_w <= 1; sl_wdata <= o_axi_wdata; sl_wstrb <= o_axi_wstrb;
            end
            if ((got_aw || (o_axi_awvalid && i_axi_awready)) &&
                (got_w || (o_axi_wvalid && i_axi_wready)) && !i_axi_bvalid) begin
                if (b_wait >= b_dly) begin
                    for (int b = 0; b < 4; b++)
                        if (sl_ws[b]) mem[sl_wa[11:2]][8*b +: 8] <= sl_wd[8*b +: 8];
                    i_axi_bvalid <= 1; i_axi_bresp <= sl_bresp;
                    got_aw <= 0; got_w <= 0; b_wait <= 0;
                end else b_wait <= b_wait + 1;
            end
            if (i_axi_bvalid && o_axi_bready) begin i_axi_bvalid <= 0; b_count <= b_count + 1; end
            if (o_axi_arvalid && i_axi_arready) begin got_ar <= 1; sl_araddr <= o_axi_araddr; end
            if ((got_ar || (o_axi_arvalid && i_axi_arready)) && !i_axi_rvalid) begin
                if (r_wait >= r_dly) begin
                    i_axi_rdata  <= sl_rforce ? sl_rval : mem[sl_ra[11:2]];
                    i_axi_rresp  <= sl_rresp; i_axi_rvalid <= 1;
                    got_ar <= 0; r_wait <= 0;
                end else r_wait <= r_wait + 1;
            end
            if (i_axi_rvalid && o_axi_rready) i_axi_rvalid <= 0;
        end
    end

    // ---------------- channel monitor (counts sampled at negedge) ----------------
    int aw_hi = 0, w_hi = 0, any_hi = 0, unstable = 0;
    logic        p_awv = 0, p_wv = 0, p_arv = 0, p_awr = 0, p_wr = 0, p_arr = 0;
    logic [11:0] p_awa = 0, p_ara = 0;
    logic [35:0] p_wd = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_axi_awvalid) aw_hi <= aw_hi + 1;
            if (o_axi_wvalid)  w_hi  <= w_hi + 1;
            if (o_axi_awvalid | o_axi_wvalid | o_axi_arvalid | o_axi_bready | o_axi_rready | o_rsp_valid)
                any_hi <= any_hi + 1;
            if ((p_awv && !p_awr && (!o_axi_awvalid || o_axi_awaddr != p_awa)) ||
                (p_wv  && !p_wr  && (!o_axi_wvalid  || {o_axi_wstrb, o_axi_wdata} != p_wd)) ||
                (p_arv && !p_arr && (!o_axi_arvalid || o_axi_araddr != p_ara)))
                unstable <= unstable + 1;
        end
        p_awv <= o_axi_awvalid & rst_n; p_awr <= i_axi_awready; p_awa <= o_axi_awaddr;
        p_wv  <= o_axi_wvalid & rst_n;  p_wr  <= i_axi_wready;  p_wd  <= {o_axi_wstrb, o_axi_wdata};
        p_arv <= o_axi_arvalid & rst_n; p_arr <= i_axi_arready; p_ara <= o_axi_araddr;
    end

    // ---------------- reference model: flat word memory with byte strobes ----------------
    logic [31:0] ref_mem [0:1023];
    initial for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    task automatic ref_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a >> 2][8*b +: 8] = d[8*b +: 8];
    endtask

    // Issue one request and collect its response; hold = cycles i_rsp_ready stays low.
    task automatic do_req(input logic we, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          output logic r_we, output logic [31:0] r_rd, output logic [1:0] r_resp);
        int t;
        @(negedge clk);
        i_req_valid = 1; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_wstrb = s;
        t = 0;
        while (!o_req_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            n_vec++; n_err++; $display("FAIL req_accept_timeout: req_ready=%b after %0d cycles, required 1", o_req_ready, t);
        end
        @(negedge clk);
        i_req_valid = 0;
        i_rsp_ready = (hold == 0);
        t = 0;
        while (!o_rsp_valid && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_vec++; n_err++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", o_rsp_valid, t);
        end
        repeat (hold) @(negedge clk);
        i_rsp_ready = 1;
        r_we = o_rsp_we; r_rd = o_rsp_rdata; r_resp = o_rsp_resp;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready, o_axi_rready, o_rsp_valid} !== 6'b0) begin
            n_err++; $display("FAIL reset_valids: got %b required 000000",
                {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_axi_bready, o_axi_rready, o_rsp_valid});
        end
        n_vec++;
        if ({o_axi_awaddr, o_axi_araddr, o_axi_wdata, o_axi_wstrb, o_rsp_rdata, o_rsp_resp, o_rsp_we} !== '0) begin
            n_err++; $display("FAIL reset_regs: awaddr=%h wdata=%h rdata=%h resp=%b required all 0",
                o_axi_awaddr, o_axi_wdata, o_rsp_rdata, o_rsp_resp);
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_vec++;
        if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b required 1", o_req_ready); end
    endtask

    task automatic test_write_read();
        logic we; logic [31:0] rd; logic [1:0] rs;
        do_req(1, 12'h000, 32'hDEADBEEF, 4'hF, 0, we, rd, rs);
        ref_write(12'h000, 32'hDEADBEEF, 4'hF);
        n_vec++;
        if ({we, rs, rd} !== {1'b1, RESP_OKAY, 32'h0}) begin
            n_err++; $display("FAIL wr_rsp: we=%b resp=%b rdata=%h required 1/00/00000000", we, rs, rd);
        end
        do_req(0, 12'h000, 32'h0, 4'h0, 0, we, rd, rs);
        n_vec++;
        if ({we, rs, rd} !== {1'b0, RESP_OKAY, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL rd_rsp: we=%b resp=%b rdata=%h required 0/00/deadbeef", we, rs, rd);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        i_req_valid = 1; i_req_we = 1; i_req_addr = 12'h010; i_req_wdata = 32'h0BADF00D; i_req_wstrb = 4'hF;
        @(negedge clk);
        i_req_valid = 0;
        ref_write(12'h010, 32'h0BADF00D, 4'hF);
        n_vec++;
        if ({o_axi_awvalid, o_axi_wvalid, o_req_ready} !== 3'b110) begin
            n_err++; $display("FAIL lat_c1_wr: aw/w/req_ready=%b required 110", {o_axi_awvalid, o_axi_wvalid, o_req_ready});
        end
        @(negedge clk);
        n_vec++;
        if ({o_axi_bready, o_axi_awvalid, o_axi_wvalid} !== 3'b100) begin
            n_err++; $display("FAIL lat_c2_b: bready/aw/w=%b required 100", {o_axi_bready, o_axi_awvalid, o_axi_wvalid});
        end
        @(negedge clk);
        n_vec++;
        if ({o_rsp_valid, o_req_ready, o_axi_bready} !== 3'b100) begin
            n_err++; $display("FAIL lat_c3_rsp: rsp_valid/req_ready/bready=%b required 100", {o_rsp_valid, o_req_ready, o_axi_bready});
        end
        @(negedge clk);
        n_vec++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            n_err++; $display("FAIL lat_c4_idle: rsp_valid/req_ready=%b required 01", {o_rsp_valid, o_req_ready});
        end
        i_req_valid = 1; i_req_we = 0; i_req_addr = 12'h010;
        @(negedge clk);
        i_req_valid = 0;
        @(negedge clk);
        n_vec++;
        if ({o_axi_rready, o_axi_arvalid} !== 2'b10) begin
            n_err++; $display("FAIL lat_rd_c2: rready/arvalid=%b required 10", {o_axi_rready, o_axi_arvalid});
        end
        @(negedge clk);
        n_vec++;
        if ({o_rsp_valid, o_rsp_rdata} !== {1'b1, ref_mem[12'h010 >> 2]}) begin
            n_err++; $display("FAIL lat_rd_c3: rsp_valid=%b rdata=%h required 1/%h", o_rsp_valid, o_rsp_rdata, ref_mem[4]);
        end
        @(negedge clk);
    endtask

    task automatic test_partial_strobe();
        logic we; logic [31:0] rd; logic [1:0] rs;
        do_req(1, 12'h00C, 32'hAABBCCDD, 4'h3, 0, we, rd, rs);
        ref_write(12'h00C, 32'hAABBCCDD, 4'h3);
        do_req(0, 12'h00C, 32'h0, 4'h0, 0, we, rd, rs);
        n_vec++;
        if (rd !== 32'h0000CCDD || rd !== ref_mem[3]) begin
            n_err++; $display("FAIL strobe_rd: rdata=%h required 0000ccdd", rd);
        end
    endtask

    task automatic test_aw_late();
        logic we; logic [31:0] rd; logic [1:0] rs;
        int aw0, w0, b0, u0;
        logic [31:0] d;
        d = $urandom;
        aw_dly = 3;
        @(negedge clk);
        aw0 = aw_hi; w0 = w_hi; b0 = b_count; u0 = unstable;
        do_req(1, 12'h020, d, 4'hF, 0, we, rd, rs);
        ref_write(12'h020, d, 4'hF);
        aw_dly = 0;
        n_vec++;
        if (aw_hi - aw0 !== 4) begin n_err++; $display("FAIL awlate_aw_cycles: got %0d required 4", aw_hi - aw0); end
        n_vec++;
        if (w_hi - w0 !== 1) begin n_err++; $display("FAIL awlate_w_cycles: got %0d required 1", w_hi - w0); end
        n_vec++;
        if (b_count - b0 !== 1) begin n_err++; $display("FAIL awlate_b_count: got %0d required 1", b_count - b0); end
        n_vec++;
        if (unstable - u0 !== 0) begin n_err++; $display("FAIL awlate_stable: %0d unstable cycles, required 0", unstable - u0); end
        do_req(0, 12'h020, 32'h0, 4'h0, 0, we, rd, rs);
        n_vec++;
        if (rd !== d) begin n_err++; $display("FAIL awlate_readback: rdata=%h required %h", rd, d); end
    endtask

    task automatic test_error_resp();
        logic we; logic [31:0] rd; logic [1:0] rs;
        sl_rresp = RESP_SLVERR; sl_rforce = 1; sl_rval = 32'h12345678;
        do_req(0, 12'h040, 32'h0, 4'h0, 0, we, rd, rs);
        sl_rresp = RESP_OKAY; sl_rforce = 0;
        n_vec++;
        if ({rs, rd} !== {2'b10, 32'h12345678}) begin
            n_err++; $display("FAIL err_rresp: resp=%b rdata=%h required 10/12345678", rs, rd);
        end
        sl_bresp = RESP_DECERR;
        do_req(1, 12'h044, 32'h55AA55AA, 4'hF, 0, we, rd, rs);
        ref_write(12'h044, 32'h55AA55AA, 4'hF);
        sl_bresp = RESP_OKAY;
        n_vec++;
        if ({we, rs, rd} !== {1'b1, 2'b11, 32'h0}) begin
            n_err++; $display("FAIL err_bresp: we=%b resp=%b rdata=%h required 1/11/00000000", we, rs, rd);
        end
    endtask

    task automatic test_rsp_hold();
        logic we; logic [31:0] rd; logic [1:0] rs;
        logic [31:0] d;
        int t;
        d = $urandom;
        do_req(1, 12'h104, d, 4'hF, 0, we, rd, rs);
        ref_write(12'h104, d, 4'hF);
        @(negedge clk);
        i_rsp_ready = 0;
        i_req_valid = 1; i_req_we = 0; i_req_addr = 12'h104;
        @(negedge clk);
        i_req_valid = 0;
        t = 0;
        while (!o_rsp_valid && t < 50) begin @(negedge clk); t++; end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({o_rsp_valid, o_rsp_rdata, o_req_ready} !== {1'b1, ref_mem[12'h104 >> 2], 1'b0}) begin
                n_err++; $display("FAIL hold_cycle%0d: valid=%b rdata=%h req_ready=%b required 1/%h/0",
                    i, o_rsp_valid, o_rsp_rdata, o_req_ready, ref_mem[12'h104 >> 2]);
            end
            if (i < 4) @(negedge clk);
        end
        i_rsp_ready = 1;
        i_req_valid = 1; i_req_we = 1; i_req_addr = 12'h108; i_req_wdata = 32'hCAFE0001; i_req_wstrb = 4'hF;
        @(negedge clk);
        n_vec++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            n_err++; $display("FAIL hold_release: rsp_valid/req_ready=%b required 01", {o_rsp_valid, o_req_ready});
        end
        @(negedge clk);
        i_req_valid = 0;
        ref_write(12'h108, 32'hCAFE0001, 4'hF);
        n_vec++;
        if (o_axi_awvalid !== 1'b1) begin n_err++; $display("FAIL hold_next_accept: awvalid=%b required 1", o_axi_awvalid); end
        t = 0;
        while (!o_rsp_valid && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic we; logic [31:0] rd; logic [1:0] rs;
        int a0;
        aw_dly = 10;
        @(negedge clk);
        i_req_valid = 1; i_req_we = 1; i_req_addr = 12'h030; i_req_wdata = 32'hFFFFFFFF; i_req_wstrb = 4'hF;
        @(negedge clk);
        i_req_valid = 0;
        @(negedge clk);
        n_vec++;
        if (o_axi_awvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: awvalid=%b required 1", o_axi_awvalid); end
        rst_n = 0;
        #1;
        n_vec++;
        if ({o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_rsp_valid} !== 4'b0) begin
            n_err++; $display("FAIL rstmid_drop: aw/w/b/rsp=%b required 0000",
                {o_axi_awvalid, o_axi_wvalid, o_axi_bready, o_rsp_valid});
        end
        repeat (2) @(negedge clk);
        aw_dly = 0;
        rst_n = 1;
        a0 = any_hi;
        repeat (5) @(negedge clk);
        n_vec++;
        if ({o_req_ready, 1'(any_hi != a0)} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_after: req_ready=%b spurious_valid_cycles=%0d required 1/0", o_req_ready, any_hi - a0);
        end
        do_req(0, 12'h030, 32'h0, 4'h0, 0, we, rd, rs);
        n_vec++;
        if (rd !== ref_mem[12'h030 >> 2]) begin
            n_err++; $display("FAIL rstmid_no_replay: rdata=%h required %h", rd, ref_mem[12'h030 >> 2]);
        end
    endtask

    task automatic test_random();
        logic we; logic [31:0] rd; logic [1:0] rs;
        logic rwe; logic [11:0] a; logic [31:0] d; logic [3:0] s;
        int u0;
        u0 = unstable;
        for (int n = 0; n < 150; n++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            rwe = 1'($urandom_range(0, 1));
            a = 12'(($urandom_range(64, 79) << 2) | $urandom_range(0, 3));
            d = $urandom; s = 4'($urandom_range(0, 15));
            do_req(rwe, a, d, s, $urandom_range(0, 2), we, rd, rs);
            n_vec++;
            if (rwe) begin
                ref_write(a, d, s);
                if ({we, rs, rd} !== {1'b1, RESP_OKAY, 32'h0}) begin
                    n_err++; $display("FAIL rand_wr[%0d]: we=%b resp=%b rdata=%h required 1/00/0", n, we, rs, rd);
                end
            end else if ({we, rs, rd} !== {1'b0, RESP_OKAY, ref_mem[a >> 2]}) begin
                n_err++; $display("FAIL rand_rd[%0d] addr=%h: we=%b resp=%b rdata=%h required 0/00/%h",
                    n, a, we, rs, rd, ref_mem[a >> 2]);
            end
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
        @(negedge clk);
        n_vec++;
        if (unstable != u0) begin n_err++; $display("FAIL rand_stable: %0d unstable cycles, required 0", unstable - u0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_partial_strobe();
        test_aw_late();
        test_error_resp();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
